serial_rx_handshake: RTL and testbench

Upstream input stage for the Moore-style processing networks: receives an asynchronous-format serial frame (start bit, 8 data bits LSB first, stop bit) on a single line, assembles it into a byte, and offers it to the downstream network through the dav_/rfd handshake. All outputs are registered and depend only on internal state (Moore outputs), so the downstream network sees stable inputs for a whole clock period. One-word holding buffer decouples frame reception from consumer latency.

---
 rtl/serial_rx_handshake_if.sv | 12 +
 rtl/serial_rx_handshake.sv | 133 +++++++++++++
 tb/tb_serial_rx_handshake.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_handshake_if.sv
// Serial line in, dav_/rfd byte handshake out; the slave modport is the receiver side.
interface serial_rx_handshake_if;
  logic       rxd;
  logic       rfd;
  logic       dav_n;
  logic [7:0] data;
  logic       err;
  logic       ovr;

  modport master (output rxd, rfd, input dav_n, data, err, ovr);
  modport slave  (input rxd, rfd, output dav_n, data, err, ovr);
endinterface

// File: rtl/serial_rx_handshake.sv
// Serial frame receiver with a one-word buffer and a Moore dav_/rfd offer.
// The buffer loads on the stop-sample edge, and dav_ falls one edge later at the earliest.
// If the buffer is still full when the next frame completes, that frame is dropped and ovr pulses.
module serial_rx_handshake #(
  parameter int BIT_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  serial_rx_handshake_if.slave  bus
);
  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW   = $clog2(BIT_CYCLES) + 1;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT1} rx_state_e;
  typedef enum logic [1:0] {O_IDLE, O_OFFER, O_CLOSE} out_state_e;

  rx_state_e  rx_q, rx_d;
  out_state_e out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] buf_q, buf_d;
  logic       full_q, full_d;
  logic [7:0] data_q, data_d;
  logic       dav_n_q, dav_n_d;
  logic       err_q, err_d;
  logic       ovr_q, ovr_d;
  logic       rel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q    <= R_IDLE;
      out_q   <= O_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      data_q  <= '0;
      dav_n_q <= 1'b1;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_q    <= rx_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      data_q  <= data_d;
      dav_n_q <= dav_n_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    rx_d    = rx_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    data_d  = data_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    rel     = 1'b0;

    // Output side is evaluated first, so a release on the stop-sample edge frees the buffer for the new byte.
    case (out_q)
      O_IDLE:  if (full_q && bus.rfd) begin
                 out_d  = O_OFFER;
                 data_d = buf_q;
               end
      O_OFFER: if (!bus.rfd) begin
                 out_d = O_CLOSE;
                 rel   = 1'b1;
               end
      O_CLOSE: if (bus.rfd) out_d = O_IDLE;
      default: out_d = O_IDLE;
    endcase
    full_d = full_q & ~rel;

    case (rx_q)
      R_IDLE:  if (!bus.rxd) begin
                 rx_d  = R_START;
                 cnt_d = '0;
               end
      R_START: if (cnt_q == CW'(HALF - 1)) begin
                 cnt_d = '0;
                 bit_d = '0;
                 rx_d  = bus.rxd ? R_IDLE : R_DATA;
               end else begin
                 cnt_d = cnt_q + 1'b1;
               end
      R_DATA:  if (cnt_q == CW'(BIT_CYCLES - 1)) begin
                 cnt_d   = '0;
                 shift_d = {bus.rxd, shift_q[7:1]};
                 bit_d   = bit_q + 3'd1;
                 if (bit_q == 3'd7) rx_d = R_STOP;
               end else begin
                 cnt_d = cnt_q + 1'b1;
               end
      R_STOP:  if (cnt_q == CW'(BIT_CYCLES - 1)) begin
                 cnt_d = '0;
                 if (!bus.rxd) begin
                   err_d = 1'b1;
                   rx_d  = R_WAIT1;
                 end else begin
                   rx_d = R_IDLE;
                   if (full_d) begin
                     ovr_d = 1'b1;
                   end else begin
                     buf_d  = shift_q;
                     full_d = 1'b1;
                   end
                 end
               end else begin
                 cnt_d = cnt_q + 1'b1;
               end
      R_WAIT1: if (bus.rxd) rx_d = R_IDLE;
      default: rx_d = R_IDLE;
    endcase

    dav_n_d = (out_d != O_OFFER);
  end

  assign bus.dav_n = dav_n_q;
  assign bus.data  = data_q;
  assign bus.err   = err_q;
  assign bus.ovr   = ovr_q;
endmodule

// File: tb/tb_serial_rx_handshake.sv
// Bench for serial_rx_handshake: frame tables, hand-built corner sequences and random frames.
// Expected event times are derived from the frame start edge t0 and scored against the DUT on every cycle.
module tb_serial_rx_handshake;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  serial_rx_handshake_if bus();
  serial_rx_handshake #(.BIT_CYCLES(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct {
    logic [7:0] val;
    logic       stop;
    int         extra_low;
    logic       exp_err;
    logic       exp_dav;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int exp_fall[$];
  logic [7:0] exp_fdat[$];
  int exp_err[$];
  int exp_ovr[$];
  logic prev_dav = 1'b1;
  logic [7:0] last_data = 8'h00;
  bit auto_ack = 1'b1;
  int rfd0_at = -1;
  int rfd1_at = -1;
  int t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // One clock: drive rxd for the coming edge, then score all outputs against the expected event queues.
  task automatic step(input logic r);
    logic fall, e_f, e_e, e_o;
    if (cyc + 1 == rfd0_at) bus.rfd = 1'b0;
    if (cyc + 1 == rfd1_at) bus.rfd = 1'b1;
    bus.rxd = r;
    @(posedge clk);
    #1;
    cyc++;
    while (exp_fall.size() > 0 && exp_fall[0] < cyc) begin
      void'(exp_fall.pop_front());
      void'(exp_fdat.pop_front());
    end
    while (exp_err.size() > 0 && exp_err[0] < cyc) void'(exp_err.pop_front());
    while (exp_ovr.size() > 0 && exp_ovr[0] < cyc) void'(exp_ovr.pop_front());
    fall = prev_dav & ~bus.dav_n;
    e_f  = (exp_fall.size() > 0) && (exp_fall[0] == cyc);
    check("dav_fall", fall, e_f);
    if (e_f) begin
      check("data_offer", bus.data, exp_fdat[0]);
      last_data = exp_fdat[0];
      void'(exp_fall.pop_front());
      void'(exp_fdat.pop_front());
    end else begin
      check("data_hold", bus.data, last_data);
    end
    e_e = (exp_err.size() > 0) && (exp_err[0] == cyc);
    check("err", bus.err, e_e);
    if (e_e) void'(exp_err.pop_front());
    e_o = (exp_ovr.size() > 0) && (exp_ovr[0] == cyc);
    check("ovr", bus.ovr, e_o);
    if (e_o) void'(exp_ovr.pop_front());
    if (auto_ack) begin
      if (!prev_dav) check("dav_rise", bus.dav_n, 1'b1);
      bus.rfd = bus.dav_n;
    end
    prev_dav = bus.dav_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Drives up to ncyc cycles of a frame; stop_len 3 lets the next start bit follow the stop sample directly.
  task automatic send_frame(input logic [7:0] v, input logic stop_v, input int stop_len,
                            input int ncyc, output int t0);
    int k;
    t0 = cyc + 1;
    for (int i = 0; i < 36 + stop_len && i < ncyc; i++) begin
      if (i < 4) step(1'b0);
      else if (i < 36) begin
        k = (i - 4) / 4;
        step(v[k]);
      end else step(stop_v);
    end
  endtask

  task automatic expect_frame(input int t0, input logic [7:0] v, input logic good, input logic ovr);
    if (good && !ovr) begin
      exp_fall.push_back(t0 + 39);
      exp_fdat.push_back(v);
    end
    if (!good) exp_err.push_back(t0 + 38);
    if (ovr) exp_ovr.push_back(t0 + 38);
  endtask

  task automatic drain_check(input string name);
    check(name, exp_fall.size() + exp_err.size() + exp_ovr.size(), 0);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_dav", bus.dav_n, 1'b1);
    check("rst_data", bus.data, 8'h00);
    check("rst_err", bus.err, 1'b0);
    check("rst_ovr", bus.ovr, 1'b0);
    exp_fall.delete();
    exp_fdat.delete();
    exp_err.delete();
    exp_ovr.delete();
    last_data = 8'h00;
    prev_dav  = 1'b1;
    rfd0_at   = -1;
    rfd1_at   = -1;
    bus.rxd   = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, required finish before 1 ms");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic [7:0] v;
    logic good;
    int slen;
    vecs[0] = '{8'hA5, 1'b1, 0,  1'b0, 1'b1};
    vecs[1] = '{8'hFF, 1'b0, 20, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 0,  1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 0,  1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 0,  1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 0,  1'b1, 1'b0};

    bus.rxd = 1'b1;
    bus.rfd = 1'b1;
    do_reset();
    idle(3);

    for (int i = 0; i < 6; i++) begin
      t = cyc + 1;
      if (vecs[i].exp_dav) begin
        exp_fall.push_back(t + 39);
        exp_fdat.push_back(vecs[i].val);
      end
      if (vecs[i].exp_err) exp_err.push_back(t + 38);
      send_frame(vecs[i].val, vecs[i].stop, 4, 40, t);
      for (int j = 0; j < vecs[i].extra_low; j++) step(1'b0);
      idle(6);
      drain_check("vec_drain");
    end

    // A one-cycle low pulse is a false start; the frame after it must still be received.
    step(1'b0);
    idle(10);
    t = cyc + 1;
    expect_frame(t, 8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 4, 40, t);
    idle(5);
    drain_check("glitch_drain");

    // Consumer not ready: the second frame overflows and only the first is ever offered.
    auto_ack = 1'b0;
    bus.rfd  = 1'b0;
    send_frame(8'h11, 1'b1, 4, 40, t);
    idle(3);
    t = cyc + 1;
    expect_frame(t, 8'h22, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 4, 40, t);
    idle(3);
    bus.rfd = 1'b1;
    exp_fall.push_back(cyc + 1);
    exp_fdat.push_back(8'h11);
    idle(3);
    check("ovr_offer_low", bus.dav_n, 1'b0);
    bus.rfd = 1'b0;
    step(1'b1);
    check("ovr_release", bus.dav_n, 1'b1);
    bus.rfd = 1'b1;
    idle(6);
    drain_check("ovr_drain");

    // Release of 9A coincides with the stop sample of 55: 55 is buffered without overflow.
    t = cyc + 1;
    expect_frame(t, 8'h9A, 1'b1, 1'b0);
    send_frame(8'h9A, 1'b1, 4, 40, t);
    idle(2);
    t = cyc + 1;
    rfd0_at = t + 38;
    rfd1_at = t + 39;
    exp_fall.push_back(t + 40);
    exp_fdat.push_back(8'h55);
    send_frame(8'h55, 1'b1, 4, 40, t);
    idle(4);
    rfd0_at = -1;
    rfd1_at = -1;
    bus.rfd = 1'b0;
    step(1'b1);
    bus.rfd = 1'b1;
    idle(4);
    drain_check("sim_drain");

    // Reset during data bits, and again while a byte is offered.
    auto_ack = 1'b1;
    send_frame(8'hC3, 1'b1, 4, 20, t);
    do_reset();
    idle(3);
    auto_ack = 1'b0;
    bus.rfd  = 1'b1;
    t = cyc + 1;
    expect_frame(t, 8'h42, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 4, 40, t);
    check("dav_low_pre_reset", bus.dav_n, 1'b0);
    do_reset();
    auto_ack = 1'b1;
    idle(3);
    t = cyc + 1;
    expect_frame(t, 8'h7E, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 4, 40, t);
    idle(5);
    drain_check("rst_drain");

    // Random frames: mixed framing errors, back-to-back starts, break runs and gaps.
    for (int n = 0; n < 30; n++) begin
      v    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      slen = good ? int'($urandom_range(3, 4)) : 4;
      t = cyc + 1;
      expect_frame(t, v, good, 1'b0);
      send_frame(v, good, slen, 40, t);
      if (!good) begin
        for (int j = 0; j < int'($urandom_range(0, 10)); j++) step(1'b0);
        step(1'b1);
      end
      idle(int'($urandom_range(0, 4)));
    end
    idle(6);
    drain_check("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
